// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl_pkg: shared constants and helpers for the MA-stage data memory
// access controller and its load/store alignment unit.
//  - RISC-V load/store funct3 encodings
//  - controller state codes
//  - access-size, lane and misalignment helpers
package dmem_ctrl_pkg;

  // Load funct3 (read[2:0])
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3 (write[1:0])
  localparam logic [1:0] F3_SB = 2'b00;
  localparam logic [1:0] F3_SH = 2'b01;
  localparam logic [1:0] F3_SW = 2'b10;

  // Controller states
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RD     = 3'd1;
  localparam logic [2:0] ST_RMW_RD = 3'd2;
  localparam logic [2:0] ST_WR     = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  function automatic logic ld_f3_ok(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  function automatic logic st_f3_ok(input logic [1:0] f3);
    return f3 != 2'b11;
  endfunction

  // Size code shared by loads (f3[1:0]) and stores (f3): 0 byte, 1 half, 2 word.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == 2'd1) && off[0]) || ((size == 2'd2) && (off != 2'b00));
  endfunction

  // Bit offset of the byte lane selected by the low address bits.
  function automatic logic [4:0] byte_lane(input logic [1:0] off);
    return {off, 3'b000};
  endfunction

  // Bit offset of the half-word lane selected by a[1].
  function automatic logic [4:0] half_lane(input logic [1:0] off);
    return {off[1], 4'b0000};
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational load extract/extend and store lane merge for a
// byte-little-endian, word-wide memory (lane0 = [7:0] at a[1:0]=00).
//  ld_f3_i   load funct3
//  st_f3_i   store funct3
//  off_i     address[1:0] of the access
//  word_i    word read from memory
//  wdata_i   right-aligned store data
//  ld_data_o extended load result
//  st_word_o word_i with the store byte/half merged in (wdata_i for SW)
module lsu_align
  import dmem_ctrl_pkg::*;
(
  input  logic [2:0]  ld_f3_i,
  input  logic [1:0]  st_f3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] ld_data_o,
  output logic [31:0] st_word_o
);

  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  always_comb begin
    ld_b = word_i[byte_lane(off_i) +: 8];
    ld_h = word_i[half_lane(off_i) +: 16];
    unique case (ld_f3_i)
      F3_LB:   ld_data_o = {{24{ld_b[7]}}, ld_b};
      F3_LH:   ld_data_o = {{16{ld_h[15]}}, ld_h};
      F3_LW:   ld_data_o = word_i;
      F3_LBU:  ld_data_o = {24'd0, ld_b};
      F3_LHU:  ld_data_o = {16'd0, ld_h};
      default: ld_data_o = '0;
    endcase
  end

  always_comb begin
    st_word_o = word_i;
    unique case (st_f3_i)
      F3_SB:   st_word_o[byte_lane(off_i) +: 8]  = wdata_i[7:0];
      F3_SH:   st_word_o[half_lane(off_i) +: 16] = wdata_i[15:0];
      F3_SW:   st_word_o = wdata_i;
      default: st_word_o = word_i;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequences MA-stage loads/stores onto a word-wide,
// multi-cycle data memory. Word accesses pass straight through, sub-word
// stores become read-modify-write, loads are extracted and extended.
//  clock/reset            rising-edge clock, synchronous active-high reset
//  read/write/address/writedata  pipeline request
//  readdata/done/misalign_fault/bus_error  completion (1-cycle pulse)
//  busywait               combinational stall to the pipeline
//  mem_*                  word-wide memory request/response
module dmem_access_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [3:0]        read,
  input  logic [2:0]        write,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              busywait,
  output logic              done,
  output logic              misalign_fault,
  output logic              bus_error,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_writedata,
  input  logic [31:0]       mem_readdata,
  input  logic              mem_busywait
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  // Abort when the counter would reach TIMEOUT on this busy cycle.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [31:0]       mwdata_q, mwdata_d;
  logic              done_q, done_d;
  logic              mis_q, mis_d;
  logic              berr_q, berr_d;

  logic              is_ld, is_st, req_valid, req_mis, tmo_hit;
  logic [31:0]       ld_ext, st_merged;

  // Exactly one of load/store enable with a listed funct3; anything else is a no-op.
  always_comb begin
    is_ld     = read[3] & ~write[2];
    is_st     = write[2] & ~read[3];
    req_valid = (is_ld && ld_f3_ok(read[2:0])) || (is_st && st_f3_ok(write[1:0]));
    req_mis   = is_ld ? misaligned(read[1:0], address[1:0])
                      : misaligned(write[1:0], address[1:0]);
    tmo_hit   = (TIMEOUT != 0) && (cnt_q == TMO_LAST);
  end

  lsu_align u_align (
    .ld_f3_i   (f3_q),
    .st_f3_i   (f3_q[1:0]),
    .off_i     (off_q),
    .word_i    (mem_readdata),
    .wdata_i   (wdata_q),
    .ld_data_o (ld_ext),
    .st_word_o (st_merged)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    off_d    = off_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    done_d   = 1'b0;
    mis_d    = 1'b0;
    berr_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          f3_d    = is_ld ? read[2:0] : {1'b0, write[1:0]};
          off_d   = address[1:0];
          wdata_d = writedata;
          maddr_d = {address[ADDR_W-1:2], 2'b00};
          cnt_d   = '0;
          if (req_mis) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            mis_d   = 1'b1;
            rdata_d = '0;
          end else if (is_ld) begin
            state_d = ST_RD;
          end else if (write[1:0] == F3_SW) begin
            state_d  = ST_WR;
            mwdata_d = writedata;
          end else begin
            state_d = ST_RMW_RD;
          end
        end
      end
      ST_RD, ST_RMW_RD, ST_WR: begin
        if (!mem_busywait) begin
          if (state_q == ST_RMW_RD) begin
            state_d  = ST_WR;
            mwdata_d = st_merged;
            cnt_d    = '0;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            rdata_d = (state_q == ST_RD) ? ld_ext : '0;
          end
        end else if (tmo_hit) begin
          // Abort before the write phase commits: an RMW that times out in
          // its read never reaches WR, so memory keeps the old word.
          state_d = ST_DONE;
          done_d  = 1'b1;
          berr_d  = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      off_q    <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      done_q   <= 1'b0;
      mis_q    <= 1'b0;
      berr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      off_q    <= off_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      done_q   <= done_d;
      mis_q    <= mis_d;
      berr_q   <= berr_d;
    end
  end

  // Request lines follow the state so they drop the cycle after completion
  // and can never overlap.
  assign mem_read       = (state_q == ST_RD) || (state_q == ST_RMW_RD);
  assign mem_write      = (state_q == ST_WR);
  assign mem_address    = maddr_q;
  assign mem_writedata  = mwdata_q;
  assign readdata       = rdata_q;
  assign done           = done_q;
  assign misalign_fault = mis_q;
  assign bus_error      = berr_q;
  assign busywait       = ((state_q != ST_IDLE) && (state_q != ST_DONE)) ||
                          ((state_q == ST_IDLE) && req_valid);

endmodule

// File: tb/tb_dmem_access_ctrl.sv
module tb_dmem_access_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  read = '0;
  logic [2:0]  write = '0;
  logic [31:0] address = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        busywait, done, misalign_fault, bus_error;
  logic        mem_read, mem_write;
  logic [31:0] mem_address, mem_writedata, mem_readdata;
  logic        mem_busywait;

  dmem_access_ctrl #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clock(clock), .reset(reset), .read(read), .write(write),
    .address(address), .writedata(writedata), .readdata(readdata),
    .busywait(busywait), .done(done), .misalign_fault(misalign_fault),
    .bus_error(bus_error), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail = 0;

  // ---------------- memory model ----------------
  logic [31:0] mem [64];
  int          lat = 3;        // cycles per memory request incl. completion cycle
  bit          stuck = 1'b0;   // hold mem_busywait high forever
  int          mcnt = 0;
  int          nread = 0, nwrite = 0, nreq_cyc = 0;
  bit          overlap = 1'b0;
  bit          pl_en = 1'b0;
  logic [5:0]  pl_idx = '0;
  logic [31:0] pl_data = '0;

  assign mem_busywait = (mem_read || mem_write) && (stuck || (mcnt < lat - 1));
  assign mem_readdata = mem[mem_address[7:2]];

  always @(posedge clock) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    if (reset || !(mem_read || mem_write)) mcnt <= 0;
    else if (mem_busywait) mcnt <= mcnt + 1;
    else begin
      mcnt <= 0;
      if (mem_write) begin
        mem[mem_address[7:2]] <= mem_writedata;
        nwrite <= nwrite + 1;
      end else nread <= nread + 1;
    end
  end

  always @(negedge clock) begin
    if (mem_read || mem_write) nreq_cyc <= nreq_cyc + 1;
    if (mem_read && mem_write) overlap <= 1'b1;
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [64];

  function automatic int acc_bytes(input bit ld, input logic [2:0] f3);
    int s = ld ? int'(f3[1:0]) : int'(f3);
    return (s == 0) ? 1 : (s == 1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input int addr,
                                           input logic [31:0] word);
    int b [4];
    int off = addr % 4;
    int v;
    for (int i = 0; i < 4; i++) b[i] = int'((word >> (8 * i)) & 32'hFF);
    case (f3)
      3'b000: begin v = b[off]; if (v >= 128) v -= 256; end
      3'b100: v = b[off];
      3'b001: begin v = b[off] + 256 * b[off + 1]; if (v >= 32768) v -= 65536; end
      3'b101: v = b[off] + 256 * b[off + 1];
      default: v = int'(word);
    endcase
    return 32'(v);
  endfunction

  function automatic logic [31:0] ref_store(input logic [2:0] f3, input int addr,
                                            input logic [31:0] word, input logic [31:0] wd);
    logic [7:0] b [4];
    int off = addr % 4;
    for (int i = 0; i < 4; i++) b[i] = word[8 * i +: 8];
    case (f3)
      3'b000: b[off] = wd[7:0];
      3'b001: begin b[off] = wd[7:0]; b[off + 1] = wd[15:8]; end
      default: for (int i = 0; i < 4; i++) b[i] = wd[8 * i +: 8];
    endcase
    return {b[3], b[2], b[1], b[0]};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic preload(input int addr, input logic [31:0] data);
    @(posedge clock); #1;
    pl_en = 1'b1; pl_idx = 6'(addr / 4); pl_data = data;
    ref_mem[addr / 4] = data;
    @(posedge clock); #1;
    pl_en = 1'b0;
  endtask

  int          r_stalls;
  bit          r_got;
  logic [31:0] r_rd;
  logic        r_mis, r_be, r_mreq;

  task automatic run_req(input bit ld, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd);
    @(posedge clock); #1;
    read = ld ? {1'b1, f3} : 4'b0;
    write = ld ? 3'b0 : {1'b1, f3[1:0]};
    address = addr; writedata = wd;
    r_stalls = 0; r_got = 0; r_rd = '0; r_mis = 0; r_be = 0; r_mreq = 0;
    for (int c = 0; c < 60 && !r_got; c++) begin
      @(negedge clock);
      if (busywait) r_stalls++;
      if (done) begin
        r_got = 1; r_rd = readdata; r_mis = misalign_fault; r_be = bus_error;
        r_mreq = mem_read | mem_write;
      end
    end
    @(posedge clock); #1;
    read = '0; write = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if ({readdata, mem_address, mem_writedata} !== 96'd0) begin
      n_fail++;
      $display("FAIL reset_data: got rd=%h ma=%h mwd=%h want all 0", readdata, mem_address, mem_writedata);
    end
    n_checks++;
    if ({busywait, done, misalign_fault, bus_error, mem_read, mem_write} !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {busywait, done, misalign_fault, bus_error, mem_read, mem_write});
    end
  endtask

  task automatic test_lw;
    int nr0, nw0;
    preload(32'h10, 32'h8899AABB);
    lat = 3; nr0 = nread; nw0 = nwrite;
    run_req(1, 3'b010, 32'h10, 32'h0);
    n_checks++;
    if (!r_got || r_rd !== 32'h8899AABB) begin
      n_fail++; $display("FAIL lw_data: got %h (done=%0d) want 8899aabb", r_rd, r_got);
    end
    n_checks++;
    if (r_stalls != 4) begin n_fail++; $display("FAIL lw_stall: got %0d want 4", r_stalls); end
    repeat (3) @(posedge clock);
    n_checks++;
    if (nread - nr0 != 1 || nwrite != nw0) begin
      n_fail++; $display("FAIL lw_accesses: got rd=%0d wr=%0d want 1/0", nread - nr0, nwrite - nw0);
    end
  endtask

  task automatic test_subword_loads;
    logic [2:0]  f3s [3] = '{3'b000, 3'b100, 3'b001};
    logic [31:0] ads [3] = '{32'h13, 32'h13, 32'h12};
    logic [31:0] exp [3] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF};
    preload(32'h10, 32'h80FF7F01);
    for (int i = 0; i < 3; i++) begin
      lat = 2;
      run_req(1, f3s[i], ads[i], 32'h0);
      n_checks++;
      if (!r_got || r_rd !== exp[i] || r_mis !== 1'b0) begin
        n_fail++; $display("FAIL subload_%0d: got %h mis=%b want %h", i, r_rd, r_mis, exp[i]);
      end
    end
  endtask

  task automatic test_rmw;
    int nr0, nw0;
    preload(32'h20, 32'h11223344);
    lat = 3; nr0 = nread; nw0 = nwrite; overlap = 0;
    run_req(0, 3'b000, 32'h21, 32'h000000CC);
    repeat (2) @(posedge clock);
    n_checks++;
    if (mem[8] !== 32'h1122CC44) begin n_fail++; $display("FAIL sb_merge: got %h want 1122cc44", mem[8]); end
    n_checks++;
    if (nread - nr0 != 1 || nwrite - nw0 != 1 || r_stalls != 7) begin
      n_fail++; $display("FAIL sb_seq: got rd=%0d wr=%0d stalls=%0d want 1/1/7", nread - nr0, nwrite - nw0, r_stalls);
    end
    preload(32'h20, 32'h11223344);
    run_req(0, 3'b001, 32'h22, 32'h0000CCCC);
    repeat (2) @(posedge clock);
    n_checks++;
    if (mem[8] !== 32'hCCCC3344) begin n_fail++; $display("FAIL sh_merge: got %h want cccc3344", mem[8]); end
    n_checks++;
    if (overlap) begin n_fail++; $display("FAIL rmw_overlap: got read&write together want never"); end
  endtask

  task automatic test_misalign;
    int rq0 = nreq_cyc;
    run_req(1, 3'b010, 32'h06, 32'h0);
    n_checks++;
    if (!r_got || r_mis !== 1'b1 || r_stalls != 1 || r_rd !== 32'h0) begin
      n_fail++; $display("FAIL mis_lw: got done=%0d mis=%b stalls=%0d rd=%h want 1/1/1/0", r_got, r_mis, r_stalls, r_rd);
    end
    run_req(0, 3'b001, 32'h05, 32'hABCD);
    n_checks++;
    if (!r_got || r_mis !== 1'b1 || r_stalls != 1) begin
      n_fail++; $display("FAIL mis_sh: got done=%0d mis=%b stalls=%0d want 1/1/1", r_got, r_mis, r_stalls);
    end
    n_checks++;
    if (nreq_cyc != rq0) begin n_fail++; $display("FAIL mis_noaccess: got %0d request cycles want 0", nreq_cyc - rq0); end
  endtask

  task automatic test_timeout;
    preload(32'h30, 32'h55555555);
    stuck = 1;
    run_req(0, 3'b010, 32'h30, 32'hDEADBEEF);
    n_checks++;
    if (!r_got || r_be !== 1'b1 || r_stalls != 5 || r_mreq !== 1'b0) begin
      n_fail++; $display("FAIL timeout: got done=%0d be=%b stalls=%0d mreq=%b want 1/1/5/0", r_got, r_be, r_stalls, r_mreq);
    end
    stuck = 0;
    @(posedge clock);
    n_checks++;
    if (mem[12] !== 32'h55555555) begin n_fail++; $display("FAIL timeout_nocommit: got %h want 55555555", mem[12]); end
    lat = 2;
    run_req(1, 3'b010, 32'h30, 32'h0);
    n_checks++;
    if (!r_got || r_be !== 1'b0 || r_rd !== 32'h55555555) begin
      n_fail++; $display("FAIL after_timeout: got %h be=%b want 55555555 be=0", r_rd, r_be);
    end
  endtask

  task automatic test_noop;
    logic [3:0] rds [3] = '{4'b1010, 4'b1011, 4'b0000};
    logic [2:0] wrs [3] = '{3'b110, 3'b000, 3'b111};
    int rq0 = nreq_cyc;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      read = rds[i]; write = wrs[i]; address = 32'h40;
      repeat (3) begin
        @(negedge clock);
        n_checks++;
        if (busywait !== 1'b0 || done !== 1'b0) begin
          n_fail++; $display("FAIL noop_%0d: got busy=%b done=%b want 0/0", i, busywait, done);
        end
      end
    end
    @(posedge clock); #1; read = '0; write = '0;
    n_checks++;
    if (nreq_cyc != rq0) begin n_fail++; $display("FAIL noop_access: got %0d request cycles want 0", nreq_cyc - rq0); end
  endtask

  task automatic test_reset_mid;
    int nw0;
    preload(32'h40, 32'hA5A5A5A5);
    nw0 = nwrite;
    @(posedge clock); #1;
    write = 3'b100; address = 32'h41; writedata = 32'h77; stuck = 1;
    @(negedge clock);
    @(negedge clock);
    n_checks++;
    if (mem_read !== 1'b1) begin n_fail++; $display("FAIL rmw_started: got mem_read=%b want 1", mem_read); end
    reset = 1'b1; write = '0;
    @(posedge clock);
    @(negedge clock);
    n_checks++;
    if ({readdata, mem_address, mem_writedata} !== 96'd0 ||
        {busywait, done, misalign_fault, bus_error, mem_read, mem_write} !== 6'd0) begin
      n_fail++; $display("FAIL reset_mid: got rd=%h ma=%h ctrl=%b want all 0", readdata, mem_address,
                         {busywait, done, misalign_fault, bus_error, mem_read, mem_write});
    end
    reset = 1'b0; stuck = 0;
    repeat (6) @(posedge clock);
    n_checks++;
    if (nwrite != nw0 || mem[16] !== 32'hA5A5A5A5) begin
      n_fail++; $display("FAIL reset_nowrite: got writes=%0d word=%h want 0 a5a5a5a5", nwrite - nw0, mem[16]);
    end
  endtask

  task automatic test_random;
    logic [2:0] lf3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0] sf3 [3] = '{3'b000, 3'b001, 3'b010};
    for (int i = 0; i < 64; i++) preload(i * 4, $urandom);
    for (int t = 0; t < 40; t++) begin
      bit ld = 1'($urandom_range(0, 1));
      logic [2:0] f3 = ld ? lf3[$urandom_range(0, 4)] : sf3[$urandom_range(0, 2)];
      int addr = $urandom_range(0, 255);
      logic [31:0] wd = $urandom;
      bit e_mis = (addr % acc_bytes(ld, f3)) != 0;
      logic [31:0] e_rd = 32'h0;
      int e_st;
      lat = $urandom_range(1, 4);
      if (e_mis) e_st = 1;
      else if (ld) begin e_st = 1 + lat; e_rd = ref_load(f3, addr, ref_mem[addr / 4]); end
      else begin
        e_st = (f3 == 3'b010) ? 1 + lat : 1 + 2 * lat;
        ref_mem[addr / 4] = ref_store(f3, addr, ref_mem[addr / 4], wd);
      end
      run_req(ld, f3, 32'(addr), wd);
      n_checks++;
      if (!r_got || r_rd !== e_rd || r_mis !== e_mis || r_be !== 1'b0) begin
        n_fail++; $display("FAIL rand_%0d_result: ld=%0d f3=%0d a=%h got rd=%h mis=%b be=%b want rd=%h mis=%b",
                           t, ld, f3, addr, r_rd, r_mis, r_be, e_rd, e_mis);
      end
      n_checks++;
      if (r_stalls != e_st) begin
        n_fail++; $display("FAIL rand_%0d_stall: got %0d want %0d", t, r_stalls, e_st);
      end
      n_checks++;
      if (mem[addr / 4] !== ref_mem[addr / 4]) begin
        n_fail++; $display("FAIL rand_%0d_mem: got %h want %h", t, mem[addr / 4], ref_mem[addr / 4]);
      end
    end
    n_checks++;
    if (overlap) begin n_fail++; $display("FAIL rand_overlap: got read&write together want never"); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    test_reset;
    for (int i = 0; i < 64; i++) preload(i * 4, 32'h0);
    test_lw;
    test_subword_loads;
    test_rmw;
    test_misalign;
    test_timeout;
    test_noop;
    test_reset_mid;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
